// File: rtl/ones_csum_checker_pkg.sv
// Shared types and constants for the ones'-complement checksum checker.
// Optional feature macro: ONES_CSUM_CHECKER_ERRCNT_EN (error counter width lives here).
package ones_csum_pkg;

  // Frame FSM: gathering words, or presenting a finished result.
  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  // Width of the optional saturating error counter.
  localparam int ERRCNT_W = 16;

  // All-ones pattern for a word of width w (ones'-complement negative zero).
  function automatic logic [63:0] all_ones(input int unsigned w);
    all_ones = (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/ones_csum_checker_eac_add.sv
// WIDTH-bit end-around-carry (ones'-complement) adder, purely combinational.
module ones_eac_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] s;

  // Plain add, then fold the carry back into bit 0; the fold cannot carry again.
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    y = s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
  end

endmodule

// File: rtl/ones_csum_checker.sv
// Receive-side ones'-complement checksum checker. Folds each accepted word into
// a running end-around-carry sum; at in_last (or when MAX_WORDS is reached)
// presents the sum, word count, pass flag and truncation flag until taken.
// Optional feature macro: ONES_CSUM_CHECKER_ERRCNT_EN adds a saturating
// err_count of failed results handed downstream.
module ones_csum_checker
  import ones_csum_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [WIDTH-1:0] res_sum,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam logic [WIDTH-1:0] ONES    = WIDTH'(all_ones(WIDTH));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  res_sum_q, res_sum_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic              res_ok_q, res_ok_d;
  logic              res_ovf_q, res_ovf_d;
  logic [WIDTH-1:0]  acc_next;
  logic [CNT_W-1:0]  count_inc;

  ones_eac_add #(.WIDTH(WIDTH)) u_eac_add (
    .a (acc_q),
    .b (in_data),
    .y (acc_next)
  );

  // Next-state, accumulator and result-register update for the frame FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    res_sum_d   = res_sum_q;
    res_count_d = res_count_q;
    res_ok_d    = res_ok_q;
    res_ovf_d   = res_ovf_q;
    count_inc   = count_q + CNT_W'(1);
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (in_last) begin
            state_d     = RESULT;
            res_sum_d   = acc_next;
            res_count_d = count_inc;
            res_ok_d    = (acc_next == ONES);
            res_ovf_d   = 1'b0;
          end else if (count_inc == CNT_MAX) begin
            // Frame hit the word limit without a checksum: report truncation.
            state_d     = RESULT;
            res_sum_d   = acc_next;
            res_count_d = CNT_MAX;
            res_ok_d    = 1'b0;
            res_ovf_d   = 1'b1;
          end else begin
            acc_d   = acc_next;
            count_d = count_inc;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      res_sum_q   <= '0;
      res_count_q <= '0;
      res_ok_q    <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      res_sum_q   <= res_sum_d;
      res_count_q <= res_count_d;
      res_ok_q    <= res_ok_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  // Handshake signals follow the state directly; results come from registers.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    res_valid = (state_q == RESULT);
    res_ok    = res_ok_q;
    res_sum   = res_sum_q;
    res_count = res_count_q;
    res_ovf   = res_ovf_q;
  end

`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Count failed results as they are handed off, saturating at all ones.
  always_comb begin
    err_count_d = err_count_q;
    if (state_q == RESULT && res_ready && !res_ok_q && err_count_q != '1)
      err_count_d = err_count_q + ERRCNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ones_csum_checker.sv
// Scoreboard bench for ones_csum_checker: the driver queues hand-computed
// results per frame, a monitor pops and compares at each result handshake.
module tb_ones_csum_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       res_valid;
  logic       res_ready;
  logic       res_ok;
  logic [3:0] res_sum;
  logic [4:0] res_count;
  logic       res_ovf;
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
  logic [15:0] err_count;
  int          exp_err = 0;
`endif

  typedef struct {
    logic [3:0] sum;
    logic       ok;
    logic [4:0] count;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ones_csum_checker #(.WIDTH(4), .MAX_WORDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ok    (res_ok),
    .res_sum   (res_sum),
    .res_count (res_count),
    .res_ovf   (res_ovf)
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every result handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", res_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_sum",   32'(res_sum),   32'(e.sum));
        chk("res_ok",    32'(res_ok),    32'(e.ok));
        chk("res_count", 32'(res_count), 32'(e.count));
        chk("res_ovf",   32'(res_ovf),   32'(e.ovf));
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
        chk("err_count_before", 32'(err_count), 32'(exp_err));
        if (!e.ok) exp_err++;
`endif
      end
    end
  end

  function automatic void expect_res(input logic [3:0] s, input logic ok,
                                     input logic [4:0] c, input logic ovf);
    exp_t e;
    e.sum = s; e.ok = ok; e.count = c; e.ovf = ovf;
    exp_q.push_back(e);
  endfunction

  // Called at posedge+#1. Presents one word and waits for its accept edge.
  // When ends_frame is set, also checks res_valid right after that edge.
  task automatic send_word(input logic [3:0] d, input logic l, input logic ends_frame);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=%0b, expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (ends_frame) chk("res_valid_latency", 32'(res_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b1;
    idle(2);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_ok",    32'(res_ok),    32'd0);
    chk("rst_res_sum",   32'(res_sum),   32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_res_ovf",   32'(res_ovf),   32'd0);
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    rst_n = 1'b1;
    idle(1);

    // Good frame: 3+5=8, 8+7=F.
    expect_res(4'hF, 1'b1, 5'd3, 1'b0);
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    send_word(4'h7, 1'b1, 1'b1);
    idle(2);

    // End-around carry: 9+9=0x12 -> 3, 3+C=F.
    expect_res(4'hF, 1'b1, 5'd3, 1'b0);
    send_word(4'h9, 1'b0, 1'b0);
    send_word(4'h9, 1'b0, 1'b0);
    send_word(4'hC, 1'b1, 1'b1);
    idle(2);

    // Corrupted checksum: 3+5+6 = E.
    expect_res(4'hE, 1'b0, 5'd3, 1'b0);
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    send_word(4'h6, 1'b1, 1'b1);
    idle(2);

    // Backpressure: result must hold for 5 cycles with input blocked.
    res_ready = 1'b0;
    expect_res(4'hF, 1'b1, 5'd3, 1'b0);
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    send_word(4'h7, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_res_sum",   32'(res_sum),   32'hF);
      chk("hold_res_count", 32'(res_count), 32'd3);
    end
    res_ready = 1'b1;
    idle(1);
    chk("post_hs_in_ready",  32'(in_ready),  32'd1);
    chk("post_hs_res_valid", 32'(res_valid), 32'd0);

    // Single-word frame: sum is the word itself.
    expect_res(4'hA, 1'b0, 5'd1, 1'b0);
    send_word(4'hA, 1'b1, 1'b1);
    idle(2);

    // All-zero frame gives positive zero, which fails.
    expect_res(4'h0, 1'b0, 5'd2, 1'b0);
    send_word(4'h0, 1'b0, 1'b0);
    send_word(4'h0, 1'b1, 1'b1);
    idle(2);

    // Truncation: 16 ones, no in_last -> 16 mod 15 = 1.
    expect_res(4'h1, 1'b0, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) send_word(4'h1, 1'b0, (i == 15));
    idle(2);

    // Reset mid-frame discards the partial frame.
    send_word(4'h4, 1'b0, 1'b0);
    send_word(4'h2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready",  32'(in_ready),  32'd1);
    chk("async_rst_res_valid", 32'(res_valid), 32'd0);
    chk("async_rst_res_sum",   32'(res_sum),   32'd0);
    chk("async_rst_res_count", 32'(res_count), 32'd0);
    idle(2);
    rst_n = 1'b1;
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    exp_err = 0;
`endif
    idle(1);
    expect_res(4'hF, 1'b1, 5'd2, 1'b0);
    send_word(4'h0, 1'b0, 1'b0);
    send_word(4'hF, 1'b1, 1'b1);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef ONES_CSUM_CHECKER_ERRCNT_EN
    chk("final_err_count", 32'(err_count), 32'(exp_err));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
